// File: rtl/two_by_one_rr_arbiter.sv
// Two-source round-robin arbiter feeding a single-entry valid/ready output register.
// Optional per-source ack counters are enabled by defining TWO_BY_ONE_RR_ARBITER_CNT_EN.
module two_by_one_rr_arbiter #(
   parameter int n = 8
) (
   input  logic         in_clk,
   input  logic         in_rst,
   input  logic [n-1:0] in_inputone,
   input  logic         in_reqone,
   output logic         out_ackone,
   input  logic [n-1:0] in_inputtwo,
   input  logic         in_reqtwo,
   output logic         out_acktwo,
   output logic [n-1:0] out_output,
   output logic         out_valid,
   input  logic         in_ready,
   output logic         out_sel
`ifdef TWO_BY_ONE_RR_ARBITER_CNT_EN
   ,
   output logic [15:0]  out_cntone,
   output logic [15:0]  out_cnttwo
`endif
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t         state_r;
   state_t         state_nxt_s;
   logic [n-1:0]   data_r;
   logic           sel_r;
   logic           ptr_r;      // index of the last granted source
   logic           load_s;
   logic           grant_two_s;

`ifdef TWO_BY_ONE_RR_ARBITER_CNT_EN
   logic [15:0]    cnt_one_r;
   logic [15:0]    cnt_two_r;
`endif

   // Load decision and round-robin grant selection.
   always_comb begin
      load_s      = 1'b0;
      grant_two_s = 1'b0;
      if ((in_reqone | in_reqtwo) & ((state_r == ST_EMPTY) | in_ready)) begin
         load_s = 1'b1;
      end else begin
         load_s = 1'b0;
      end
      // On a tie, the source that did not win last time gets the grant.
      if (in_reqone & in_reqtwo) begin
         grant_two_s = ~ptr_r;
      end else if (in_reqtwo) begin
         grant_two_s = 1'b1;
      end else begin
         grant_two_s = 1'b0;
      end
   end

   // Acks are suppressed during reset because the capture is discarded.
   always_comb begin
      out_ackone = 1'b0;
      out_acktwo = 1'b0;
      if (load_s & ~in_rst) begin
         out_ackone = ~grant_two_s;
         out_acktwo = grant_two_s;
      end else begin
         out_ackone = 1'b0;
         out_acktwo = 1'b0;
      end
   end

   // Next-state logic for the holding register occupancy.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_EMPTY: begin
            if (load_s) begin
               state_nxt_s = ST_FULL;
            end else begin
               state_nxt_s = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (load_s) begin
               state_nxt_s = ST_FULL;
            end else if (in_ready) begin
               state_nxt_s = ST_EMPTY;
            end else begin
               state_nxt_s = ST_FULL;
            end
         end
         default: state_nxt_s = ST_EMPTY;
      endcase
   end

   // State, output data, select and round-robin pointer registers.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state_r <= ST_EMPTY;
         data_r  <= {n{1'b0}};
         sel_r   <= 1'b0;
         ptr_r   <= 1'b1;
      end else begin
         state_r <= state_nxt_s;
         if (load_s) begin
            data_r <= grant_two_s ? in_inputtwo : in_inputone;
            sel_r  <= grant_two_s;
            ptr_r  <= grant_two_s;
         end
      end
   end

`ifdef TWO_BY_ONE_RR_ARBITER_CNT_EN
   // Per-source ack counters, wrapping at 16 bits.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         cnt_one_r <= 16'd0;
         cnt_two_r <= 16'd0;
      end else begin
         if (out_ackone) begin
            cnt_one_r <= cnt_one_r + 16'd1;
         end
         if (out_acktwo) begin
            cnt_two_r <= cnt_two_r + 16'd1;
         end
      end
   end

   assign out_cntone = cnt_one_r;
   assign out_cnttwo = cnt_two_r;
`endif

   assign out_output = data_r;
   assign out_valid  = (state_r == ST_FULL);
   assign out_sel    = sel_r;

endmodule

// File: tb/tb_two_by_one_rr_arbiter.sv
// Self-checking bench: directed test-plan sequences plus randomized traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_two_by_one_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] d1, d2;
   logic       req1, req2, ready;
   logic       ack1, ack2, valid, sel;
   logic [7:0] dout;
`ifdef TWO_BY_ONE_RR_ARBITER_CNT_EN
   logic [15:0] cnt1, cnt2;
`endif

   int vecs = 0;
   int errs = 0;

   // Model: contents of the one-entry buffer, who won last, and ack totals.
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_sel;
   logic       m_last;
   int         m_cnt1, m_cnt2;
   logic       m_ack1, m_ack2;

   two_by_one_rr_arbiter #(.n(8)) dut (
      .in_clk(clk), .in_rst(rst),
      .in_inputone(d1), .in_reqone(req1), .out_ackone(ack1),
      .in_inputtwo(d2), .in_reqtwo(req2), .out_acktwo(ack2),
      .out_output(dout), .out_valid(valid), .in_ready(ready), .out_sel(sel)
`ifdef TWO_BY_ONE_RR_ARBITER_CNT_EN
      , .out_cntone(cnt1), .out_cnttwo(cnt2)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive at negedge, check acks, then check registered outputs after the edge.
   task automatic step(input logic r, input logic q1, input logic q2, input logic rd,
                       input logic [7:0] a, input logic [7:0] b);
      logic accept;
      int   winner;
      @(negedge clk);
      rst = r; req1 = q1; req2 = q2; ready = rd; d1 = a; d2 = b;
      #1;
      accept = !r && (q1 || q2) && (!m_valid || rd);
      if (q1 && q2)  winner = (m_last == 1'b1) ? 0 : 1;
      else if (q2)   winner = 1;
      else           winner = 0;
      m_ack1 = accept && (winner == 0);
      m_ack2 = accept && (winner == 1);
      chk("ackone", ack1, m_ack1);
      chk("acktwo", ack2, m_ack2);
      @(posedge clk);
      if (r) begin
         m_valid = 1'b0; m_data = 8'h00; m_sel = 1'b0; m_last = 1'b1;
         m_cnt1 = 0; m_cnt2 = 0;
      end else if (accept) begin
         m_valid = 1'b1;
         m_data  = (winner == 1) ? b : a;
         m_sel   = (winner == 1);
         m_last  = (winner == 1);
         if (winner == 1) m_cnt2 = (m_cnt2 + 1) % 65536;
         else             m_cnt1 = (m_cnt1 + 1) % 65536;
      end else if (m_valid && rd) begin
         m_valid = 1'b0;
      end
      #1;
      chk("valid", valid, m_valid);
      chk("output", dout, m_data);
      chk("sel", sel, m_sel);
`ifdef TWO_BY_ONE_RR_ARBITER_CNT_EN
      chk("cntone", cnt1, m_cnt1[15:0]);
      chk("cnttwo", cnt2, m_cnt2[15:0]);
`endif
   endtask

   initial begin
      logic [7:0] alt_exp [6];
      logic [7:0] ra, rb;
      logic       rq1, rq2, rr, rrd;
      m_valid = 1'b0; m_data = 8'h00; m_sel = 1'b0; m_last = 1'b1;
      m_cnt1 = 0; m_cnt2 = 0;
      rst = 1'b1; req1 = 1'b0; req2 = 1'b0; ready = 1'b0; d1 = 8'h00; d2 = 8'h00;

      // Reset with both requests high.
      step(1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 8'h22);
      step(1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 8'h22);
      chk("lit_rst_valid", valid, 32'd0);
      chk("lit_rst_output", dout, 32'h00);
      step(1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 8'h22);
      chk("lit_first_grant", dout, 32'h11);

      // Single source streaming.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 8'h00);
      chk("lit_single_out", dout, 32'hA5);
      chk("lit_single_sel", sel, 32'd0);

      // Alternation after a fresh reset.
      step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      alt_exp = '{8'h11, 8'h22, 8'h11, 8'h22, 8'h11, 8'h22};
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 8'h22);
         chk("lit_alt_out", dout, alt_exp[i]);
         chk("lit_alt_sel", sel, i % 2);
      end

      // Backpressure holds 22, then source one wins next.
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 8'h22);
         chk("lit_bp_out", dout, 32'h22);
      end
      step(1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 8'h22);
      chk("lit_bp_next", dout, 32'h11);

      // Drain with no requests.
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 8'h44);
      chk("lit_drain_valid", valid, 32'd0);
      chk("lit_drain_hold", dout, 32'h11);

      // Counted grants then reset while full.
      step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 8'h10 + 8'(i), 8'h00);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h20 + 8'(i));
`ifdef TWO_BY_ONE_RR_ARBITER_CNT_EN
      chk("lit_cntone", cnt1, 32'd5);
      chk("lit_cnttwo", cnt2, 32'd3);
`endif
      chk("lit_full_before_rst", valid, 32'd1);
      step(1'b1, 1'b1, 1'b1, 1'b0, 8'h55, 8'h66);
      chk("lit_midrst_valid", valid, 32'd0);
`ifdef TWO_BY_ONE_RR_ARBITER_CNT_EN
      chk("lit_midrst_cnt", {cnt1, cnt2}, 32'd0);
`endif

      // Randomized traffic; data is held while a request waits for its ack.
      ra = 8'h00; rb = 8'h00; rq1 = 1'b0; rq2 = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (!rq1 || m_ack1) ra = 8'($urandom);
         if (!rq2 || m_ack2) rb = 8'($urandom);
         rq1 = ($urandom_range(0, 3) != 0);
         rq2 = ($urandom_range(0, 3) != 0);
         rrd = ($urandom_range(0, 3) != 0);
         rr  = ($urandom_range(0, 99) == 0);
         step(rr, rq1, rq2, rrd, ra, rb);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
